// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Runtime-programmable VGA timing generator. Four preset modes plus
//            one custom mode held in shadow registers written through a small
//            register port. Mode and timing changes take effect only at the
//            frame boundary. It also provides line/frame strobes and a frame
//            counter.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_W  = 11,
    parameter int V_W  = 10,
    parameter int FC_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [2:0]      mode_sel_i,
    input  logic            cfg_we_i,
    input  logic [3:0]      cfg_addr_i,
    input  logic [H_W-1:0]  cfg_data_i,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            display_on_o,
    output logic [H_W-1:0]  hpos_o,
    output logic [V_W-1:0]  vpos_o,
    output logic            line_start_o,
    output logic            frame_start_o,
    output logic [FC_W-1:0] frame_count_o,
    output logic [2:0]      mode_active_o
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Active timing, used by the counters and sync decode for the whole frame
    logic [H_W-1:0]  ha_q, hfp_q, hsw_q, hbp_q;
    logic            hpol_q;
    logic [V_W-1:0]  va_q, vfp_q, vsw_q, vbp_q;
    logic            vpol_q;
    logic [2:0]      mode_q;

    // Timing to be loaded at the next frame boundary
    logic [H_W-1:0]  ha_d, hfp_d, hsw_d, hbp_d;
    logic            hpol_d;
    logic [V_W-1:0]  va_d, vfp_d, vsw_d, vbp_d;
    logic            vpol_d;

    // Custom-mode shadow registers
    logic [H_W-1:0]  sh_ha_q, sh_hfp_q, sh_hsw_q, sh_hbp_q;
    logic            sh_hpol_q;
    logic [V_W-1:0]  sh_va_q, sh_vfp_q, sh_vsw_q, sh_vbp_q;
    logic            sh_vpol_q;

    // Counters and registered outputs
    logic [H_W-1:0]  hpos_q;
    logic [V_W-1:0]  vpos_q;
    logic            hsync_q;
    logic            vsync_q;
    logic [FC_W-1:0] fc_q;
    // Low only in the cycle right after reset release so strobes stay quiet
    // until the counters have actually started running
    logic            run_q;

    // ------------------------------------------------------------------------
    // Derived timing (all arithmetic wraps at the field width)
    // ------------------------------------------------------------------------
    logic [H_W-1:0]  w_hs_start, w_hs_end, w_h_max;
    logic [V_W-1:0]  w_vs_start, w_vs_end, w_v_max;
    logic            w_line_end;
    logic            w_frame_end;
    logic            w_h_in_sync;
    logic            w_v_in_sync;
    logic [2:0]      w_mode_norm;

    assign w_hs_start  = ha_q + hfp_q;
    assign w_hs_end    = w_hs_start + hsw_q - H_W'(1);
    assign w_h_max     = w_hs_end + hbp_q;
    assign w_vs_start  = va_q + vfp_q;
    assign w_vs_end    = w_vs_start + vsw_q - V_W'(1);
    assign w_v_max     = w_vs_end + vbp_q;

    assign w_line_end  = (hpos_q == w_h_max);
    assign w_frame_end = w_line_end && (vpos_q == w_v_max);

    // A zero sync width would make the window wrap; treat it as "no pulse"
    assign w_h_in_sync = (hsw_q != '0) && (hpos_q >= w_hs_start) && (hpos_q <= w_hs_end);
    assign w_v_in_sync = (vsw_q != '0) && (vpos_q >= w_vs_start) && (vpos_q <= w_vs_end);

    // Unsupported selections fall back to mode 0
    assign w_mode_norm = (mode_sel_i > 3'd4) ? 3'd0 : mode_sel_i;

    // Select the timing set that the next frame boundary will load
    always_comb begin
        ha_d   = H_W'(640);  hfp_d = H_W'(16); hsw_d = H_W'(96);  hbp_d = H_W'(48);  hpol_d = 1'b0;
        va_d   = V_W'(480);  vfp_d = V_W'(10); vsw_d = V_W'(2);   vbp_d = V_W'(33);  vpol_d = 1'b0;
        case (w_mode_norm)
            3'd1: begin
                ha_d = H_W'(768);  hfp_d = H_W'(24); hsw_d = H_W'(80);  hbp_d = H_W'(104); hpol_d = 1'b0;
                va_d = V_W'(576);  vfp_d = V_W'(1);  vsw_d = V_W'(3);   vbp_d = V_W'(17);  vpol_d = 1'b1;
            end
            3'd2: begin
                ha_d = H_W'(800);  hfp_d = H_W'(40); hsw_d = H_W'(128); hbp_d = H_W'(88);  hpol_d = 1'b1;
                va_d = V_W'(600);  vfp_d = V_W'(1);  vsw_d = V_W'(4);   vbp_d = V_W'(23);  vpol_d = 1'b1;
            end
            3'd3: begin
                ha_d = H_W'(1024); hfp_d = H_W'(24); hsw_d = H_W'(136); hbp_d = H_W'(160); hpol_d = 1'b0;
                va_d = V_W'(768);  vfp_d = V_W'(3);  vsw_d = V_W'(6);   vbp_d = V_W'(29);  vpol_d = 1'b0;
            end
            3'd4: begin
                ha_d = sh_ha_q;    hfp_d = sh_hfp_q; hsw_d = sh_hsw_q;  hbp_d = sh_hbp_q;  hpol_d = sh_hpol_q;
                va_d = sh_va_q;    vfp_d = sh_vfp_q; vsw_d = sh_vsw_q;  vbp_d = sh_vbp_q;  vpol_d = sh_vpol_q;
            end
            default: ;
        endcase
    end

    // Shadow register writes; a write in the boundary cycle lands after the
    // reload has already sampled the old shadow value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_ha_q  <= H_W'(640); sh_hfp_q <= H_W'(16); sh_hsw_q <= H_W'(96); sh_hbp_q <= H_W'(48);
            sh_hpol_q <= 1'b0;
            sh_va_q  <= V_W'(480); sh_vfp_q <= V_W'(10); sh_vsw_q <= V_W'(2);  sh_vbp_q <= V_W'(33);
            sh_vpol_q <= 1'b0;
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                4'd0:    sh_ha_q   <= cfg_data_i;
                4'd1:    sh_hfp_q  <= cfg_data_i;
                4'd2:    sh_hsw_q  <= cfg_data_i;
                4'd3:    sh_hbp_q  <= cfg_data_i;
                4'd4:    sh_hpol_q <= cfg_data_i[0];
                4'd5:    sh_va_q   <= cfg_data_i[V_W-1:0];
                4'd6:    sh_vfp_q  <= cfg_data_i[V_W-1:0];
                4'd7:    sh_vsw_q  <= cfg_data_i[V_W-1:0];
                4'd8:    sh_vbp_q  <= cfg_data_i[V_W-1:0];
                4'd9:    sh_vpol_q <= cfg_data_i[0];
                default: ;
            endcase
        end
    end

    // Reload active timing and reported mode only at the frame boundary
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ha_q   <= H_W'(640); hfp_q <= H_W'(16); hsw_q <= H_W'(96); hbp_q <= H_W'(48);
            hpol_q <= 1'b0;
            va_q   <= V_W'(480); vfp_q <= V_W'(10); vsw_q <= V_W'(2);  vbp_q <= V_W'(33);
            vpol_q <= 1'b0;
            mode_q <= 3'd0;
        end else if (w_frame_end) begin
            ha_q   <= ha_d;   hfp_q <= hfp_d; hsw_q <= hsw_d; hbp_q <= hbp_d;
            hpol_q <= hpol_d;
            va_q   <= va_d;   vfp_q <= vfp_d; vsw_q <= vsw_d; vbp_q <= vbp_d;
            vpol_q <= vpol_d;
            mode_q <= w_mode_norm;
        end
    end

    // Horizontal and vertical beam counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else if (w_line_end) begin
            hpos_q <= '0;
            vpos_q <= (vpos_q == w_v_max) ? '0 : vpos_q + V_W'(1);
        end else begin
            hpos_q <= hpos_q + H_W'(1);
        end
    end

    // Sync outputs registered from the current counters (one cycle behind)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hsync_q <= w_h_in_sync ? hpol_q : ~hpol_q;
            vsync_q <= w_v_in_sync ? vpol_q : ~vpol_q;
        end
    end

    // Completed-frame counter, wraps naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fc_q <= '0;
        end else if (w_frame_end) begin
            fc_q <= fc_q + FC_W'(1);
        end
    end

    // Strobe enable, set on the first clock after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign display_on_o  = (hpos_q < ha_q) && (vpos_q < va_q);
    assign hpos_o        = hpos_q;
    assign vpos_o        = vpos_q;
    assign line_start_o  = run_q && (hpos_q == '0);
    assign frame_start_o = run_q && (hpos_q == '0) && (vpos_q == '0);
    assign frame_count_o = fc_q;
    assign mode_active_o = mode_q;

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised VGA timing generator. It is the runtime-programmable successor to the fixed-table sync generator.
- Provides four preset modes plus one custom mode, loaded through a small register-write port.
- Mode and timing changes are glitch-free: they apply only at the frame boundary.
- Adds line/frame strobes and a frame counter.
- Sits between the pixel clock and the glyph/pixel pipeline, which consumes hpos/vpos/display_on.

Parameters:
H_W, 11, width of hpos and horizontal timing fields
V_W, 10, width of vpos and vertical timing fields
FC_W, 8, width of frame_count

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
mode_sel  in  3  0=640x480, 1=768x576, 2=800x600, 3=1024x768, 4=custom, 5-7 treated as 0
cfg_we  in  1  custom-register write strobe
cfg_addr  in  4  custom field select (see Behaviour)
cfg_data  in  H_W  write data, LSBs used for narrower fields
hsync  out  1  horizontal sync, polarity per active mode
vsync  out  1  vertical sync, polarity per active mode
display_on  out  1  beam inside active area
hpos  out  H_W  horizontal counter
vpos  out  V_W  vertical counter
line_start  out  1  one-cycle pulse while hpos==0
frame_start  out  1  one-cycle pulse while hpos==0 and vpos==0
frame_count  out  FC_W  completed frames, wraps
mode_active  out  3  mode currently applied (normalised, 5-7 reported as 0)

Behaviour:
- Reset (async assert, sync to clk on release):
  - hpos=0, vpos=0, frame_count=0, mode_active=0.
  - Active timing = preset 0.
  - hsync=1, vsync=1; line_start=0, frame_start=0.
  - Custom shadow regs reset to 640x480 timings.
- Presets (active, fp, sync, bp, polarity; 1=positive):
  - H: 640/16/96/48/0, 768/24/80/104/0, 800/40/128/88/1, 1024/24/136/160/0.
  - V: 480/10/2/33/0, 576/1/3/17/1, 600/1/4/23/1, 768/3/6/29/0.
- Derived, all modulo field width:
  - hs_start = ha+hfp
  - hs_end = hs_start+hsw-1
  - h_max = hs_end+hbp
  - Vertical values are computed the same way.
- Counters, every clk:
  - hpos <= (hpos==h_max) ? 0 : hpos+1.
  - vpos advances only when hpos==h_max; it wraps to 0 when also vpos==v_max.
- hsync/vsync are registered from the current counters, so they lag hpos/vpos by one cycle.
  - hsync <= (hs_start<=hpos<=hs_end) XNOR h_pol, i.e. active level = h_pol.
  - vsync uses the same rule with the vertical fields.
- display_on is combinational: hpos<ha && vpos<va.
- line_start and frame_start are combinational decodes of the counters, so they are aligned with hpos/vpos.
- Frame boundary = hpos==h_max && vpos==v_max. At that edge:
  - Active timing is reloaded from mode_sel, either a preset or a copy of the custom shadow.
  - mode_active updates.
  - frame_count increments.
- mode_sel and shadow changes never alter timing mid-frame.
- Custom shadow write: on cfg_we the addressed field is written.
  - Addresses 0-4: ha, hfp, hsw, hbp, h_pol(bit0).
  - Addresses 5-9: va, vfp, vsw, vbp, v_pol(bit0).
  - Addresses 10-15: ignored.
  - Writes take effect at the next frame boundary (with mode_sel=4).
- A write in the boundary cycle itself is NOT included in that reload.
- Field edge cases:
  - hsw=0 or vsw=0: no sync pulse (inactive level held).
  - ha=0: display_on stays 0.
  - No range checking otherwise: wrapped totals are used as computed.
- Reset asserted mid-frame: immediate return to reset values; pending mode_sel is applied at the first boundary after release.

Test Plan:
- Reset, mode_sel=0, run one frame: h_max=799, v_max=524. hsync low for hpos 656..751, seen one cycle later. vsync low for vpos 490..491. frame_start after 420000 cycles. frame_count=1.
- Switch mode_sel 0->3 mid-frame: the current frame completes with 800-wide lines. The next frame has h_max=1343, v_max=805, mode_active=3. hsync/vsync stay negative polarity.
- mode_sel=2: hsync high for hpos 840..967, vsync high for vpos 601..604 (positive polarity). display_on=1 exactly for hpos<800, vpos<600.
- Custom mode, write ha=100, hfp=4, hsw=8, hbp=8, h_pol=1, va=50, vfp=2, vsw=2, vbp=2, v_pol=1, mode_sel=4: after the boundary, h_max=119, v_max=55. hsync high for hpos 104..111.
- cfg_we in the boundary cycle, custom active: the old value is used for the following frame and the new value one frame later. hsw=0 write: hsync constant at inactive level.
- Assert rst_n low mid-line for 1 cycle: outputs return to reset values asynchronously. Counting restarts from 0,0 after release. frame_count=0.
